// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//
// Purpose:
//   Issue/retire scheduler between the EX stage and the multiplier and divider
//   units. Launches at most one unit operation per EX instruction, stalls EX
//   while the operation is outstanding and holds the captured result for the
//   instruction until it leaves EX. An operation whose instruction was killed
//   is drained (its result discarded) before a new one may issue.
//
// Build option:
//   MULDIV_WDT_EN  - when defined, a watchdog abandons any operation that waits
//                    TIMEOUT_CYC cycles for its unit and pulses wdt_err. When
//                    undefined, the scheduler waits for ready indefinitely and
//                    wdt_err is tied low.
//
// Parameters:
//   TIMEOUT_CYC    - watchdog limit in cycles spent in MUL/DIV/DRAIN (2..256).
//
// Ports:
//   clk                  pipeline clock, rising edge
//   rst                  asynchronous reset, active low
//   mul_req, div_req     EX instruction needs the multiplier / divider
//   flush                EX instruction is killed
//   pipe_stall           external stall, EX instruction cannot advance
//   mul_ready, div_ready unit result valid
//   mul_hi/lo, div_hi/lo unit results
//   mul_start, div_start one-cycle launch pulse to the unit
//   md_stall             hold EX and upstream this cycle
//   res_valid            res_hi/res_lo belong to the EX instruction
//   res_hi, res_lo       captured result
//   busy                 a unit operation is outstanding
//   wdt_err              one-cycle watchdog timeout pulse
//
// States:
//   state | meaning
//   IDLE  | no operation outstanding; may launch for the EX instruction
//   MUL   | multiply outstanding for the EX instruction
//   DIV   | divide outstanding for the EX instruction
//   DONE  | result captured, waiting for the instruction to leave EX
//   DRAIN | instruction killed; waiting for the orphaned unit result
// -----------------------------------------------------------------------------
module muldiv_sched #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_req,
    input  logic        div_req,
    input  logic        flush,
    input  logic        pipe_stall,
    input  logic        mul_ready,
    input  logic        div_ready,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        mul_start,
    output logic        div_start,
    output logic        md_stall,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        busy,
    output logic        wdt_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [7:0] WDT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        sel_mul_q, sel_mul_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;

    logic        mul_start_c;
    logic        div_start_c;
    logic        md_stall_c;
    logic        waiting;
    logic        drain_ready;
    logic        wdt_hit;

    assign waiting = (state_q == S_MUL) || (state_q == S_DIV) ||
                     (state_q == S_DRAIN);

    // In DRAIN only the unit that was launched may retire the orphaned op.
    assign drain_ready = sel_mul_q ? mul_ready : div_ready;

`ifdef MULDIV_WDT_EN
    logic [7:0] wdt_cnt_q, wdt_cnt_d;

    assign wdt_hit = waiting && (wdt_cnt_q == WDT_LAST);

    // Restarts from zero on every entry into a waiting state, including the
    // MUL/DIV -> DRAIN hop, so a drain gets its own full timeout window.
    always_comb begin
        wdt_cnt_d = 8'd0;
        if (waiting && (state_d == state_q)) begin
            wdt_cnt_d = wdt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_q <= 8'd0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
`else
    logic unused_wdt_limit;

    // The limit has no function without the watchdog.
    assign unused_wdt_limit = ^WDT_LAST;
    assign wdt_hit          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_mul_d   = sel_mul_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        mul_start_c = 1'b0;
        div_start_c = 1'b0;
        md_stall_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    if (mul_req) begin
                        mul_start_c = 1'b1;
                        md_stall_c  = 1'b1;
                        sel_mul_d   = 1'b1;
                        state_d     = S_MUL;
                    end else if (div_req) begin
                        div_start_c = 1'b1;
                        md_stall_c  = 1'b1;
                        sel_mul_d   = 1'b0;
                        state_d     = S_DIV;
                    end
                end
            end

            S_MUL: begin
                md_stall_c = 1'b1;
                if (wdt_hit) begin
                    state_d = S_IDLE;
                end else if (mul_ready) begin
                    // A result arriving with the kill is simply dropped.
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        res_hi_d = mul_hi;
                        res_lo_d = mul_lo;
                        state_d  = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            S_DIV: begin
                md_stall_c = 1'b1;
                if (wdt_hit) begin
                    state_d = S_IDLE;
                end else if (div_ready) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        res_hi_d = div_hi;
                        res_lo_d = div_lo;
                        state_d  = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            S_DONE: begin
                // Requests are still asserted by the same instruction here;
                // they must not launch a second operation.
                if (!pipe_stall || flush) begin
                    state_d = S_IDLE;
                end
            end

            S_DRAIN: begin
                // A new instruction needing a unit must wait for the drain.
                md_stall_c = mul_req | div_req;
                if (wdt_hit || drain_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sel_mul_q <= 1'b0;
            res_hi_q  <= 32'd0;
            res_lo_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            sel_mul_q <= sel_mul_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
        end
    end

    // The request-dependent outputs are gated so they drop the moment reset
    // asserts, not just once the state register has cleared.
    assign mul_start = rst & mul_start_c;
    assign div_start = rst & div_start_c;
    assign md_stall  = rst & md_stall_c;

    assign res_valid = (state_q == S_DONE);
    assign busy      = waiting;
    assign wdt_err   = wdt_hit;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

`ifdef MULDIV_WDT_EN
    localparam int TB_TIMEOUT = 40;
`else
    localparam int TB_TIMEOUT = 40;
`endif

    logic        clk;
    logic        rst;
    logic        mul_req, div_req, flush, pipe_stall;
    logic        mul_ready, div_ready;
    logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
    logic        mul_start, div_start, md_stall, res_valid, busy, wdt_err;
    logic [31:0] res_hi, res_lo;

    // {mul_start, div_start, md_stall, res_valid, busy, wdt_err}
    logic [5:0]  flags;
    logic [5:0]  exp;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_MSTRT = 6'b101000;
    localparam logic [5:0] F_DSTRT = 6'b011000;
    localparam logic [5:0] F_WAIT  = 6'b001010;
    localparam logic [5:0] F_DONE  = 6'b000100;
    localparam logic [5:0] F_DRNOS = 6'b000010;
    localparam logic [5:0] F_WDT   = 6'b001011;

    muldiv_sched #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mul_req    (mul_req),
        .div_req    (div_req),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .mul_ready  (mul_ready),
        .div_ready  (div_ready),
        .mul_hi     (mul_hi),
        .mul_lo     (mul_lo),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .md_stall   (md_stall),
        .res_valid  (res_valid),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .busy       (busy),
        .wdt_err    (wdt_err)
    );

    assign flags = {mul_start, div_start, md_stall, res_valid, busy, wdt_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        mul_req    = 1'b0;
        div_req    = 1'b0;
        flush      = 1'b0;
        pipe_stall = 1'b0;
        mul_ready  = 1'b0;
        div_ready  = 1'b0;
        mul_hi     = 32'd0;
        mul_lo     = 32'd0;
        div_hi     = 32'd0;
        div_lo     = 32'd0;
    endtask

    // Leaves the bench one time unit after a rising edge, DUT in IDLE.
    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (flags !== F_NONE) begin errors++; $display("FAIL reset flags: got %b expected %b", flags, F_NONE); end
        checks++;
        if ({res_hi, res_lo} !== 64'd0) begin errors++; $display("FAIL reset result: got %h expected 0", {res_hi, res_lo}); end
        mul_req = 1'b1;
        #1;
        checks++;
        if (flags !== F_NONE) begin errors++; $display("FAIL reset req_held: got %b expected %b", flags, F_NONE); end
        rst = 1'b1;
        #1;
        checks++;
        if (flags !== F_MSTRT) begin errors++; $display("FAIL reset first_start: got %b expected %b", flags, F_MSTRT); end
        tick();
        checks++;
        if (flags !== F_WAIT) begin errors++; $display("FAIL reset after_start: got %b expected %b", flags, F_WAIT); end
        apply_reset();
    endtask

    task automatic test_mul();
        for (int c = 0; c <= 5; c++) begin
            mul_req   = (c <= 4);
            mul_ready = (c == 3);
            mul_hi    = (c == 3) ? 32'h1 : 32'hDEAD_0001;
            mul_lo    = (c == 3) ? 32'h2 : 32'hDEAD_0002;
            #1;
            if (c == 0)      exp = F_MSTRT;
            else if (c <= 3) exp = F_WAIT;
            else if (c == 4) exp = F_DONE;
            else             exp = F_NONE;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL mul c%0d flags: got %b expected %b", c, flags, exp); end
            if (c >= 4) begin
                checks++;
                if (res_hi !== 32'h1 || res_lo !== 32'h2) begin
                    errors++; $display("FAIL mul c%0d result: got %h_%h expected 00000001_00000002", c, res_hi, res_lo);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_div_hold();
        for (int c = 0; c <= 37; c++) begin
            div_req    = (c <= 36);
            div_ready  = (c == 33);
            div_hi     = (c == 33) ? 32'hAAAA_5555 : 32'hDEAD_BEEF;
            div_lo     = (c == 33) ? 32'h1234_5678 : 32'hCAFE_F00D;
            pipe_stall = (c == 34) || (c == 35);
            #1;
            if (c == 0)       exp = F_DSTRT;
            else if (c <= 33) exp = F_WAIT;
            else if (c <= 36) exp = F_DONE;
            else              exp = F_NONE;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL div_hold c%0d flags: got %b expected %b", c, flags, exp); end
            if (c >= 34 && c <= 36) begin
                checks++;
                if ({res_hi, res_lo} !== 64'hAAAA5555_12345678) begin
                    errors++; $display("FAIL div_hold c%0d result: got %h expected aaaa555512345678", c, {res_hi, res_lo});
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_flush_drain();
        for (int c = 0; c <= 35; c++) begin
            div_req   = 1'b1;
            flush     = (c == 5);
            div_ready = (c == 33);
            div_hi    = 32'h0BAD_0BAD;
            div_lo    = 32'h0BAD_0BAD;
            #1;
            if (c == 0 || c == 34) exp = F_DSTRT;
            else                   exp = F_WAIT;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL flush_drain c%0d flags: got %b expected %b", c, flags, exp); end
            tick();
        end
        apply_reset();
    endtask

    task automatic test_flush_cases();
        for (int c = 0; c <= 11; c++) begin
            clear_inputs();
            case (c)
                0, 1, 6: mul_req = 1'b1;
                2: begin
                    mul_req = 1'b1; flush = 1'b1; mul_ready = 1'b1;
                    mul_hi = 32'd55; mul_lo = 32'd66;
                end
                4, 7: begin mul_req = 1'b1; flush = 1'b1; end
                9:  div_ready = 1'b1;
                10: mul_ready = 1'b1;
                default: ;
            endcase
            #1;
            case (c)
                0, 6:     exp = F_MSTRT;
                1, 2, 7:  exp = F_WAIT;
                8, 9, 10: exp = F_DRNOS;
                default:  exp = F_NONE;
            endcase
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL flush_cases c%0d flags: got %b expected %b", c, flags, exp); end
            if (c == 3) begin
                checks++;
                if ({res_hi, res_lo} !== 64'd0) begin errors++; $display("FAIL flush_cases discard: got %h expected 0", {res_hi, res_lo}); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        for (int c = 0; c <= 5; c++) begin
            mul_req   = (c <= 4);
            div_req   = (c <= 4);
            div_ready = (c == 1) || (c == 2);
            div_hi    = 32'd99;
            div_lo    = 32'd99;
            mul_ready = (c == 3);
            mul_hi    = (c == 3) ? 32'd7 : 32'd0;
            mul_lo    = (c == 3) ? 32'd8 : 32'd0;
            #1;
            if (c == 0)      exp = F_MSTRT;
            else if (c <= 3) exp = F_WAIT;
            else if (c == 4) exp = F_DONE;
            else             exp = F_NONE;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL priority c%0d flags: got %b expected %b", c, flags, exp); end
            if (c == 4) begin
                checks++;
                if (res_hi !== 32'd7 || res_lo !== 32'd8) begin
                    errors++; $display("FAIL priority result: got %0d_%0d expected 7_8", res_hi, res_lo);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 3; c++) begin
            div_req = 1'b1;
            #1;
            exp = (c == 0) ? F_DSTRT : F_WAIT;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL reset_mid c%0d flags: got %b expected %b", c, flags, exp); end
            tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (flags !== F_NONE) begin errors++; $display("FAIL reset_mid async flags: got %b expected %b", flags, F_NONE); end
        checks++;
        if ({res_hi, res_lo} !== 64'd0) begin errors++; $display("FAIL reset_mid async result: got %h expected 0", {res_hi, res_lo}); end
        tick();
        rst       = 1'b1;
        div_req   = 1'b0;
        div_ready = 1'b1;
        div_hi    = 32'h5151_5151;
        div_lo    = 32'h1515_1515;
        #1;
        checks++;
        if (flags !== F_NONE) begin errors++; $display("FAIL reset_mid late_ready flags: got %b expected %b", flags, F_NONE); end
        tick();
        div_ready = 1'b0;
        #1;
        checks++;
        if (flags !== F_NONE || {res_hi, res_lo} !== 64'd0) begin
            errors++; $display("FAIL reset_mid ignored: got %b/%h expected %b/0", flags, {res_hi, res_lo}, F_NONE);
        end
        div_req = 1'b1;
        #1;
        checks++;
        if (flags !== F_DSTRT) begin errors++; $display("FAIL reset_mid restart: got %b expected %b", flags, F_DSTRT); end
        apply_reset();
    endtask

    task automatic test_watchdog();
`ifdef MULDIV_WDT_EN
        for (int c = 0; c <= TB_TIMEOUT + 1; c++) begin
            mul_req = (c <= TB_TIMEOUT);
            #1;
            if (c == 0)               exp = F_MSTRT;
            else if (c < TB_TIMEOUT)  exp = F_WAIT;
            else if (c == TB_TIMEOUT) exp = F_WDT;
            else                      exp = F_NONE;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL watchdog c%0d flags: got %b expected %b", c, flags, exp); end
            tick();
        end
`else
        for (int c = 0; c <= 100; c++) begin
            mul_req = 1'b1;
            #1;
            exp = (c == 0) ? F_MSTRT : F_WAIT;
            checks++;
            if (flags !== exp) begin errors++; $display("FAIL no_watchdog c%0d flags: got %b expected %b", c, flags, exp); end
            tick();
        end
`endif
        apply_reset();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_mul();
        test_div_hold();
        test_flush_drain();
        test_flush_cases();
        test_priority();
        test_reset_mid();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
